pwm_dt_gen: RTL and testbench

Downstream consumer of the 10-bit free-running period counter in the PWM path. Compares the counter value against a double-buffered duty register to form a raw PWM level. Drives complementary high-side/low-side gate outputs with programmable dead-time inserted on every transition. Duty updates take effect only at period boundaries, which prevents glitches and partial periods.

---
 rtl/pwm_pkg.sv | 26 ++
 rtl/pwm_dt_gen_if.sv | 34 +++
 rtl/pwm_deadtime_fsm.sv | 86 ++++++++
 rtl/pwm_dt_gen.sv | 66 ++++++
 tb/tb_pwm_dt_gen.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared defaults and dead-time FSM state encoding for the PWM path.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int c_DEF_WIDTH    = 10;
    localparam int c_DEF_DEADTIME = 4;
    localparam int c_DEF_DT_W     = 4;

    localparam logic [1:0] c_ST_L_ON    = 2'd0;
    localparam logic [1:0] c_ST_DT_TO_H = 2'd1;
    localparam logic [1:0] c_ST_H_ON    = 2'd2;
    localparam logic [1:0] c_ST_DT_TO_L = 2'd3;

    typedef enum logic [1:0] {
        L_ON    = c_ST_L_ON,
        DT_TO_H = c_ST_DT_TO_H,
        H_ON    = c_ST_H_ON,
        DT_TO_L = c_ST_DT_TO_L
    } dt_state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_dt_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_dt_gen_if
//  Description : Counter, duty-write and gate-drive bundle of the PWM generator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pwm_dt_gen_if
    import pwm_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH
) ();

    logic [WIDTH-1:0] cnt;
    logic             cnt_en;
    logic [WIDTH-1:0] duty_in;
    logic             duty_wr;
    logic             duty_pend;
    logic             period_done;
    logic             pwm_raw;
    logic             pwm_h;
    logic             pwm_l;

    modport master (
        output cnt, cnt_en, duty_in, duty_wr,
        input  duty_pend, period_done, pwm_raw, pwm_h, pwm_l
    );

    modport slave (
        input  cnt, cnt_en, duty_in, duty_wr,
        output duty_pend, period_done, pwm_raw, pwm_h, pwm_l
    );

endinterface
`default_nettype wire

// File: rtl/pwm_deadtime_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_deadtime_fsm
//  Description : Complementary gate drive with dead-time inserted on every edge of pwm_raw.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_deadtime_fsm
    import pwm_pkg::*;
#(
    parameter int DEADTIME = c_DEF_DEADTIME,
    parameter int DT_W     = c_DEF_DT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic pwm_raw,
    output logic pwm_h,
    output logic pwm_l
);

    localparam logic [DT_W-1:0] c_DT_LOAD = DT_W'(DEADTIME - 1);

    dt_state_t       r_state;
    logic [DT_W-1:0] r_dt;
    logic            r_h;
    logic            r_l;

    // Reset parks in DT_TO_L so the low side only turns on after a full dead-time.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= DT_TO_L;
            r_dt    <= c_DT_LOAD;
            r_h     <= 1'b0;
            r_l     <= 1'b0;
        end else begin
            case (r_state)
                L_ON: begin
                    if (pwm_raw) begin
                        r_state <= DT_TO_H;
                        r_dt    <= c_DT_LOAD;
                        r_l     <= 1'b0;
                    end
                end
                DT_TO_H: begin
                    if (!pwm_raw) begin
                        r_state <= DT_TO_L;
                        r_dt    <= c_DT_LOAD;
                    end else if (r_dt == '0) begin
                        r_state <= H_ON;
                        r_h     <= 1'b1;
                    end else begin
                        r_dt <= r_dt - 1'b1;
                    end
                end
                H_ON: begin
                    if (!pwm_raw) begin
                        r_state <= DT_TO_L;
                        r_dt    <= c_DT_LOAD;
                        r_h     <= 1'b0;
                    end
                end
                DT_TO_L: begin
                    if (pwm_raw) begin
                        r_state <= DT_TO_H;
                        r_dt    <= c_DT_LOAD;
                    end else if (r_dt == '0) begin
                        r_state <= L_ON;
                        r_l     <= 1'b1;
                    end else begin
                        r_dt <= r_dt - 1'b1;
                    end
                end
                default: begin
                    r_state <= DT_TO_L;
                    r_dt    <= c_DT_LOAD;
                    r_h     <= 1'b0;
                    r_l     <= 1'b0;
                end
            endcase
        end
    end

    assign pwm_h = r_h;
    assign pwm_l = r_l;

endmodule
`default_nettype wire

// File: rtl/pwm_dt_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_dt_gen
//  Description : Double-buffered duty compare against the period counter, plus dead-time gate drive.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_dt_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH    = c_DEF_WIDTH,
    parameter int DEADTIME = c_DEF_DEADTIME,
    parameter int DT_W     = c_DEF_DT_W
) (
    input  logic          clk,
    input  logic          reset,
    pwm_dt_gen_if.slave   bus
);

    logic [WIDTH-1:0] r_active_duty;
    logic [WIDTH-1:0] r_pending;
    logic             r_duty_pend;
    logic             r_period_done;
    logic             r_pwm_raw;
    logic             w_boundary;

    assign w_boundary = bus.cnt_en && (bus.cnt == '1);

    // A write on the boundary cycle lands after the commit, so it waits a full period.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_active_duty <= '0;
            r_pending     <= '0;
            r_duty_pend   <= 1'b0;
            r_period_done <= 1'b0;
            r_pwm_raw     <= 1'b0;
        end else begin
            r_period_done <= w_boundary;
            r_pwm_raw     <= (bus.cnt < r_active_duty);
            if (w_boundary && r_duty_pend) begin
                r_active_duty <= r_pending;
                r_duty_pend   <= 1'b0;
            end
            if (bus.duty_wr) begin
                r_pending   <= bus.duty_in;
                r_duty_pend <= 1'b1;
            end
        end
    end

    assign bus.duty_pend   = r_duty_pend;
    assign bus.period_done = r_period_done;
    assign bus.pwm_raw     = r_pwm_raw;

    pwm_deadtime_fsm #(
        .DEADTIME (DEADTIME),
        .DT_W     (DT_W)
    ) u_deadtime (
        .clk     (clk),
        .reset   (reset),
        .pwm_raw (r_pwm_raw),
        .pwm_h   (bus.pwm_h),
        .pwm_l   (bus.pwm_l)
    );

endmodule
`default_nettype wire

// File: tb/tb_pwm_dt_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_dt_gen
//  Description : Directed and randomized bench for pwm_dt_gen against a run-length reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_dt_gen;
    import pwm_pkg::*;

    localparam int c_W   = 10;
    localparam int c_DT  = 4;
    localparam int c_DTW = 4;
    localparam int c_TOP = (1 << c_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pwm_dt_gen_if #(.WIDTH(c_W)) bus ();

    pwm_dt_gen #(
        .WIDTH    (c_W),
        .DEADTIME (c_DT),
        .DT_W     (c_DTW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: outputs follow the length of the current run of equal pwm_raw samples.
    int m_active, m_pending, run1, run0;
    bit m_pend, m_pd, m_raw, m_h, m_l;
    int n_raw, n_h, n_l_low, n_l_high, n_pd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit nraw;
        if (reset) begin
            m_active = 0; m_pending = 0; m_pend = 0; m_pd = 0;
            m_raw = 0; m_h = 0; m_l = 0; run1 = 0; run0 = 1;
        end else begin
            nraw = (int'(bus.cnt) < m_active);
            if (m_raw) begin
                if (run1 < 100) run1++;
                run0 = 0;
            end else begin
                if (run0 < 100) run0++;
                run1 = 0;
            end
            m_h  = (run1 >= c_DT + 1);
            m_l  = (run0 >= c_DT + 1);
            m_pd = bus.cnt_en && (int'(bus.cnt) == c_TOP);
            if (m_pd && m_pend) begin
                m_active = m_pending;
                m_pend   = 0;
            end
            if (bus.duty_wr) begin
                m_pending = int'(bus.duty_in);
                m_pend    = 1;
            end
            m_raw = nraw;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("pwm_raw", bus.pwm_raw, m_raw);
        check("pwm_h", bus.pwm_h, m_h);
        check("pwm_l", bus.pwm_l, m_l);
        check("duty_pend", bus.duty_pend, m_pend);
        check("period_done", bus.period_done, m_pd);
        check("no_overlap", bus.pwm_h & bus.pwm_l, 0);
        n_raw    += int'(bus.pwm_raw);
        n_h      += int'(bus.pwm_h);
        n_l_low  += int'(!bus.pwm_l);
        n_l_high += int'(bus.pwm_l);
        n_pd     += int'(bus.period_done);
        if (bus.cnt_en) bus.cnt = bus.cnt + 10'd1;
        bus.duty_wr = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_to(input int c);
        int k = 0;
        while (int'(bus.cnt) != c && k < 2048) begin
            tick();
            k++;
        end
        if (k >= 2048) begin
            checks++;
            failures++;
            $error("FAIL run_to observed=%0d expected=%0d", bus.cnt, c);
        end
    endtask

    task automatic write(input int d);
        bus.duty_in = 10'(d);
        bus.duty_wr = 1'b1;
        tick();
    endtask

    task automatic clr();
        n_raw = 0; n_h = 0; n_l_low = 0; n_l_high = 0; n_pd = 0;
    endtask

    initial begin
        reset       = 1'b1;
        bus.cnt     = '0;
        bus.cnt_en  = 1'b0;
        bus.duty_in = '0;
        bus.duty_wr = 1'b0;
        clr();
        run(3);
        check("rst_pwm_h", bus.pwm_h, 0);
        check("rst_pwm_l", bus.pwm_l, 0);
        check("rst_pwm_raw", bus.pwm_raw, 0);
        check("rst_duty_pend", bus.duty_pend, 0);
        check("rst_period_done", bus.period_done, 0);

        // Counter running with duty 0: low side comes up after the dead-time.
        reset      = 1'b0;
        bus.cnt_en = 1'b1;
        clr();
        run(3);
        check("l_delay_low", n_l_high, 0);
        run(1);
        check("l_after_dt", bus.pwm_l, 1);

        // Duty 256 written mid-period, committed at the boundary.
        run_to(500);
        check("pd_before_boundary", n_pd, 0);
        write(256);
        check("pend_256", bus.duty_pend, 1);
        run_to(c_TOP);
        check("pend_hold_256", bus.duty_pend, 1);
        tick();
        check("boundary_pulse", bus.period_done, 1);
        check("pend_clear_256", bus.duty_pend, 0);
        clr();
        run(1024);
        check("raw_256", n_raw, 256);
        check("h_256", n_h, 252);
        check("l_low_256", n_l_low, 260);
        check("pd_count_256", n_pd, 1);

        // Last write before the boundary wins.
        run_to(10);
        write(100);
        run_to(20);
        write(300);
        run_to(c_TOP);
        tick();
        clr();
        run(1024);
        check("raw_300", n_raw, 300);
        check("h_300", n_h, 296);
        check("l_low_300", n_l_low, 304);

        // Write on the boundary cycle waits one more period.
        run_to(600);
        write(512);
        run_to(c_TOP);
        write(2);
        check("pend_after_bnd_wr", bus.duty_pend, 1);
        clr();
        run(1024);
        check("raw_512", n_raw, 512);
        check("pend_clear_2", bus.duty_pend, 0);
        clr();
        run(1024);
        check("raw_2", n_raw, 2);
        check("h_swallowed", n_h, 0);
        check("l_low_2", n_l_low, 6);

        // Duty 0 with a counter stall.
        write(0);
        run_to(c_TOP);
        tick();
        run_to(300);
        bus.cnt_en = 1'b0;
        clr();
        run(50);
        check("stall_raw", n_raw, 0);
        check("stall_h", n_h, 0);
        check("stall_l", n_l_high, 50);
        check("stall_pd", n_pd, 0);
        bus.cnt_en = 1'b1;

        // Reset during high-side conduction discards pending duty.
        write(512);
        run_to(c_TOP);
        tick();
        run_to(100);
        check("h_on_512", bus.pwm_h, 1);
        write(700);
        check("pend_700", bus.duty_pend, 1);
        reset = 1'b1;
        tick();
        check("rst_mid_h", bus.pwm_h, 0);
        check("rst_mid_l", bus.pwm_l, 0);
        check("rst_mid_pend", bus.duty_pend, 0);
        reset = 1'b0;
        clr();
        run(3);
        check("rst_mid_l_delay", n_l_high, 0);
        run(1);
        check("rst_mid_l_back", bus.pwm_l, 1);
        run_to(c_TOP);
        tick();
        clr();
        run(1024);
        check("raw_discarded", n_raw, 0);

        // Randomized writes, stalls and occasional resets.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                bus.duty_in = ($urandom_range(0, 2) == 0) ? 10'($urandom_range(0, 9)) : 10'($urandom);
                bus.duty_wr = 1'b1;
            end
            bus.cnt_en = ($urandom_range(0, 9) != 0);
            reset      = ($urandom_range(0, 1999) == 0);
            tick();
        end
        reset      = 1'b0;
        bus.cnt_en = 1'b1;
        run(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
